// File: rtl/l15_simple_transducer_pkg.sv
// Shared L1.5 request/return encodings and widths for the simple transducer.
package l15_simple_transducer_pkg;

  localparam int L15_THREADID_WIDTH = 1;
  localparam int TLB_CSM_WIDTH      = 33;
  localparam int L15_AMO_OP_WIDTH   = 4;

  // PCX request types
  localparam logic [4:0] PCX_REQTYPE_LOAD  = 5'b00000;
  localparam logic [4:0] PCX_REQTYPE_STORE = 5'b00001;

  // CPX return types
  localparam logic [3:0] CPX_RESTYPE_LOAD      = 4'h0;
  localparam logic [3:0] CPX_RESTYPE_STORE_ACK = 4'h4;
  localparam logic [3:0] CPX_RESTYPE_INVAL     = 4'h3;
  localparam logic [3:0] CPX_RESTYPE_INTERRUPT = 4'h7;

  // Transducer FSM encodings
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_REQ       = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;
  localparam logic [1:0] ST_RESP      = 2'd3;

  // Request type for a client operation
  function automatic logic [4:0] pcx_rqtype(input logic we);
    return we ? PCX_REQTYPE_STORE : PCX_REQTYPE_LOAD;
  endfunction

endpackage

// File: rtl/l15_simple_transducer.sv
// Single-outstanding valid/ready load/store port to L1.5 transducer protocol,
// with response routing, unsolicited-return draining and a response watchdog.
module l15_simple_transducer
  import l15_simple_transducer_pkg::*;
#(
  parameter int unsigned                    TIMEOUT_CYCLES = 4096,
  parameter logic [L15_THREADID_WIDTH-1:0]  THREADID       = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  // client request
  input  logic                          req_val,
  output logic                          req_rdy,
  input  logic                          req_we,
  input  logic [39:0]                   req_addr,
  input  logic [2:0]                    req_size,
  input  logic [63:0]                   req_wdata,
  input  logic                          req_nc,
  // client response
  output logic                          rsp_val,
  input  logic                          rsp_rdy,
  output logic [63:0]                   rsp_rdata,
  output logic [1:0]                    rsp_err,
  output logic                          rsp_timeout,
  // request to L1.5
  output logic                          transducer_l15_val,
  output logic [4:0]                    transducer_l15_rqtype,
  output logic                          transducer_l15_nc,
  output logic [2:0]                    transducer_l15_size,
  output logic [L15_THREADID_WIDTH-1:0] transducer_l15_threadid,
  output logic [39:0]                   transducer_l15_address,
  output logic [63:0]                   transducer_l15_data,
  output logic [63:0]                   transducer_l15_data_next_entry,
  output logic [L15_AMO_OP_WIDTH-1:0]   transducer_l15_amo_op,
  output logic                          transducer_l15_prefetch,
  output logic                          transducer_l15_invalidate_cacheline,
  output logic                          transducer_l15_blockstore,
  output logic                          transducer_l15_blockinitstore,
  output logic [1:0]                    transducer_l15_l1rplway,
  output logic [TLB_CSM_WIDTH-1:0]      transducer_l15_csm_data,
  input  logic                          l15_transducer_ack,
  input  logic                          l15_transducer_header_ack,
  // return from L1.5
  input  logic                          l15_transducer_val,
  input  logic [3:0]                    l15_transducer_returntype,
  input  logic [63:0]                   l15_transducer_data_0,
  input  logic [63:0]                   l15_transducer_data_1,
  input  logic [1:0]                    l15_transducer_error,
  output logic                          transducer_l15_req_ack
);

  logic [1:0]  state;
  logic        pend_we;
  logic [39:0] pend_addr;
  logic [2:0]  pend_size;
  logic [63:0] pend_wdata;
  logic        pend_nc;
  logic [4:0]  pend_rqtype;
  logic [31:0] wd_cnt;
  logic [63:0] rdata_q;
  logic [1:0]  err_q;

  logic        ret_live;
  logic        load_match;
  logic        store_match;
  logic        rsp_match;
  logic        timeout_hit;
  logic [63:0] ret_rdata;
  logic        unused_ok;

  assign unused_ok = l15_transducer_header_ack;

  // Return decode; a return coinciding with the request ack is treated as
  // already in WAIT_RESP so it is routed rather than dropped.
  always_comb begin
    ret_live    = l15_transducer_val &&
                  ((state == ST_WAIT_RESP) || ((state == ST_REQ) && l15_transducer_ack));
    load_match  = ret_live && !pend_we && (l15_transducer_returntype == CPX_RESTYPE_LOAD);
    store_match = ret_live &&  pend_we && (l15_transducer_returntype == CPX_RESTYPE_STORE_ACK);
    rsp_match   = load_match || store_match;
    ret_rdata   = '0;
    if (load_match) begin
      ret_rdata = pend_addr[3] ? l15_transducer_data_1 : l15_transducer_data_0;
    end
    // a matching return in the expiry cycle wins over the watchdog
    timeout_hit = (TIMEOUT_CYCLES != 0) && (state == ST_WAIT_RESP) &&
                  (wd_cnt == TIMEOUT_CYCLES - 32'd1) && !rsp_match;
  end

  // Client-facing and L1.5-facing outputs
  always_comb begin
    req_rdy                 = rst_n && (state == ST_IDLE);
    rsp_val                 = (state == ST_RESP);
    rsp_rdata               = rdata_q;
    rsp_err                 = err_q;
    rsp_timeout             = rst_n && timeout_hit;
    transducer_l15_req_ack  = rst_n && l15_transducer_val;
    transducer_l15_val      = (state == ST_REQ);
    transducer_l15_rqtype   = pend_rqtype;
    transducer_l15_nc       = pend_nc;
    transducer_l15_size     = pend_size;
    transducer_l15_threadid = THREADID;
    transducer_l15_address  = pend_addr;
    transducer_l15_data     = pend_wdata;
    transducer_l15_data_next_entry      = '0;
    transducer_l15_amo_op               = '0;
    transducer_l15_prefetch             = 1'b0;
    transducer_l15_invalidate_cacheline = 1'b0;
    transducer_l15_blockstore           = 1'b0;
    transducer_l15_blockinitstore       = 1'b0;
    transducer_l15_l1rplway             = '0;
    transducer_l15_csm_data             = '0;
  end

  // Transaction FSM, request capture, response capture and watchdog
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pend_we     <= 1'b0;
      pend_addr   <= '0;
      pend_size   <= '0;
      pend_wdata  <= '0;
      pend_nc     <= 1'b0;
      pend_rqtype <= '0;
      wd_cnt      <= '0;
      rdata_q     <= '0;
      err_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_val) begin
            pend_we     <= req_we;
            pend_addr   <= req_addr;
            pend_size   <= req_size;
            pend_wdata  <= req_wdata;
            pend_nc     <= req_nc;
            pend_rqtype <= pcx_rqtype(req_we);
            state       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (l15_transducer_ack) begin
            wd_cnt <= '0;
            if (rsp_match) begin
              rdata_q <= ret_rdata;
              err_q   <= l15_transducer_error;
              state   <= ST_RESP;
            end else begin
              state <= ST_WAIT_RESP;
            end
          end
        end
        ST_WAIT_RESP: begin
          if (rsp_match) begin
            rdata_q <= ret_rdata;
            err_q   <= l15_transducer_error;
            state   <= ST_RESP;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= 2'b11;
            state   <= ST_RESP;
          end else begin
            wd_cnt <= wd_cnt + 32'd1;
          end
        end
        default: begin
          if (rsp_rdy) begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l15_simple_transducer.sv
// Self-checking bench for l15_simple_transducer: directed scenarios plus a
// randomized transaction loop checked against a behavioural model.
module tb_l15_simple_transducer;

  logic        clk;
  logic        rst_n;
  logic        req_val, req_rdy, req_we, req_nc;
  logic [39:0] req_addr;
  logic [2:0]  req_size;
  logic [63:0] req_wdata;
  logic        rsp_val, rsp_rdy, rsp_timeout;
  logic [63:0] rsp_rdata;
  logic [1:0]  rsp_err;
  logic        t_val, t_nc, t_pref, t_inv, t_bs, t_bis;
  logic [4:0]  t_rqtype;
  logic [2:0]  t_size;
  logic [0:0]  t_tid;
  logic [39:0] t_addr;
  logic [63:0] t_data, t_dne;
  logic [3:0]  t_amo;
  logic [1:0]  t_rpl;
  logic [32:0] t_csm;
  logic        l_ack, l_hack, l_val, t_req_ack;
  logic [3:0]  l_rtype;
  logic [63:0] l_d0, l_d1;
  logic [1:0]  l_err;

  int checks = 0;
  int errors = 0;
  int ack_pulses = 0;

  l15_simple_transducer #(.TIMEOUT_CYCLES(16), .THREADID(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_we(req_we), .req_addr(req_addr),
    .req_size(req_size), .req_wdata(req_wdata), .req_nc(req_nc),
    .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .transducer_l15_val(t_val), .transducer_l15_rqtype(t_rqtype), .transducer_l15_nc(t_nc),
    .transducer_l15_size(t_size), .transducer_l15_threadid(t_tid),
    .transducer_l15_address(t_addr), .transducer_l15_data(t_data),
    .transducer_l15_data_next_entry(t_dne), .transducer_l15_amo_op(t_amo),
    .transducer_l15_prefetch(t_pref), .transducer_l15_invalidate_cacheline(t_inv),
    .transducer_l15_blockstore(t_bs), .transducer_l15_blockinitstore(t_bis),
    .transducer_l15_l1rplway(t_rpl), .transducer_l15_csm_data(t_csm),
    .l15_transducer_ack(l_ack), .l15_transducer_header_ack(l_hack),
    .l15_transducer_val(l_val), .l15_transducer_returntype(l_rtype),
    .l15_transducer_data_0(l_d0), .l15_transducer_data_1(l_d1),
    .l15_transducer_error(l_err), .transducer_l15_req_ack(t_req_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // count return-consumed cycles, sampled mid-cycle
  always @(negedge clk) if (t_req_ack === 1'b1) ack_pulses++;

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "bench timeout");
  end

  // ---------------- behavioural model ----------------
  function automatic logic [63:0] model_rdata(input logic we, input logic [39:0] a,
                                               input logic [63:0] d0, input logic [63:0] d1);
    if (we) return 64'd0;
    return (((a >> 3) & 40'd1) != 0) ? d1 : d0;
  endfunction

  function automatic logic [113:0] model_req(input logic we, input logic nc, input logic [2:0] sz,
                                             input logic [39:0] a, input logic [63:0] wd);
    logic [4:0] rq;
    rq = we ? 5'd1 : 5'd0;
    return {1'b1, rq, nc, sz, a, wd};
  endfunction

  // ---------------- drivers (no checking) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_val = 0; req_we = 0; req_addr = '0; req_size = '0; req_wdata = '0; req_nc = 0;
    rsp_rdy = 0; l_ack = 0; l_hack = 0; l_val = 0; l_rtype = '0; l_d0 = '0; l_d1 = '0; l_err = '0;
  endtask

  task automatic drive_req(input logic we, input logic [39:0] a, input logic [2:0] sz,
                           input logic [63:0] wd, input logic nc);
    req_val = 1; req_we = we; req_addr = a; req_size = sz; req_wdata = wd; req_nc = nc;
  endtask

  task automatic scramble_req();
    req_val = 0; req_we = $urandom_range(0, 1);
    req_addr = {8'h00, $urandom}; req_size = 3'($urandom_range(0, 7));
    req_wdata = {$urandom, $urandom}; req_nc = $urandom_range(0, 1);
  endtask

  task automatic drive_ret(input logic [3:0] ty, input logic [63:0] d0, input logic [63:0] d1,
                           input logic [1:0] e);
    l_val = 1; l_rtype = ty; l_d0 = d0; l_d1 = d1; l_err = e;
  endtask

  task automatic drop_ret();
    l_val = 0; l_rtype = '0; l_d0 = '0; l_d1 = '0; l_err = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    tick(); tick();
    checks++;
    if ({req_rdy, rsp_val, rsp_timeout, t_val, t_req_ack, rsp_rdata, rsp_err, t_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b rval=%b to=%b val=%b addr=%h, required all 0",
               req_rdy, rsp_val, rsp_timeout, t_val, t_addr);
    end
    checks++;
    if ({t_dne, t_amo, t_pref, t_inv, t_bs, t_bis, t_rpl, t_csm, t_tid} !== '0) begin
      errors++;
      $display("FAIL tied_zero: got dne=%h amo=%h csm=%h, required 0", t_dne, t_amo, t_csm);
    end
    rst_n = 1;
    #1;
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_rdy: got %b required 1", req_rdy);
    end
  endtask

  task automatic test_load();
    int a0;
    drive_req(0, 40'h0000_1008, 3'd3, 64'h0, 0);
    tick();
    scramble_req();
    checks++;
    if ({t_val, t_rqtype, t_nc, t_size, t_addr, t_data} !== model_req(0, 0, 3'd3, 40'h1008, 64'h0)) begin
      errors++;
      $display("FAIL load_req_fields: got val=%b rq=%h addr=%h, required val=1 rq=0 addr=1008",
               t_val, t_rqtype, t_addr);
    end
    tick(); tick();
    l_ack = 1; tick(); l_ack = 0;
    checks++;
    if (t_val !== 1'b0) begin
      errors++;
      $display("FAIL load_val_drop: got %b required 0", t_val);
    end
    a0 = ack_pulses;
    drive_ret(4'h0, 64'h1111, 64'h2222, 2'b00);
    tick(); drop_ret(); tick();
    checks++;
    if ({rsp_val, rsp_rdata, rsp_err} !== {1'b1, 64'h2222, 2'b00}) begin
      errors++;
      $display("FAIL load_rsp: got val=%b data=%h err=%h, required 1 2222 0", rsp_val, rsp_rdata, rsp_err);
    end
    checks++;
    if (ack_pulses - a0 !== 1) begin
      errors++;
      $display("FAIL load_req_ack_count: got %0d required 1", ack_pulses - a0);
    end
    rsp_rdy = 1; tick(); rsp_rdy = 0;
  endtask

  task automatic test_store_hold();
    drive_req(1, 40'h00_0000_0040, 3'd2, 64'hDEAD_BEEF, 1);
    tick();
    scramble_req();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({t_val, t_rqtype, t_nc, t_size, t_addr, t_data} !==
          model_req(1, 1, 3'd2, 40'h40, 64'hDEAD_BEEF)) begin
        errors++;
        $display("FAIL store_hold[%0d]: got val=%b rq=%h nc=%b sz=%h data=%h, required 1 01 1 2 deadbeef",
                 i, t_val, t_rqtype, t_nc, t_size, t_data);
      end
      tick();
    end
    l_ack = 1; tick(); l_ack = 0;
    drive_ret(4'h4, 64'h5555, 64'h6666, 2'b01);
    tick(); drop_ret();
    checks++;
    if ({rsp_val, rsp_rdata, rsp_err} !== {1'b1, 64'h0, 2'b01}) begin
      errors++;
      $display("FAIL store_rsp: got val=%b data=%h err=%h, required 1 0 1", rsp_val, rsp_rdata, rsp_err);
    end
    rsp_rdy = 1; tick(); rsp_rdy = 0;
  endtask

  task automatic test_inv_drop();
    drive_req(0, 40'h12_3456_7890, 3'd3, 64'h0, 0);
    tick(); scramble_req();
    l_ack = 1; tick(); l_ack = 0;
    drive_ret(4'h3, 64'hAAAA, 64'hBBBB, 2'b10);
    #1;
    checks++;
    if (t_req_ack !== 1'b1) begin
      errors++;
      $display("FAIL inv_req_ack: got %b required 1", t_req_ack);
    end
    tick(); drop_ret();
    checks++;
    if (rsp_val !== 1'b0) begin
      errors++;
      $display("FAIL inv_no_rsp: got rsp_val=%b required 0", rsp_val);
    end
    tick();
    drive_ret(4'h0, 64'hC0DE_0000, 64'hC0DE_0001, 2'b00);
    tick(); drop_ret();
    checks++;
    if ({rsp_val, rsp_rdata, rsp_err} !== {1'b1, 64'hC0DE_0000, 2'b00}) begin
      errors++;
      $display("FAIL inv_then_load: got val=%b data=%h err=%h, required 1 c0de0000 0",
               rsp_val, rsp_rdata, rsp_err);
    end
    rsp_rdy = 1; tick(); rsp_rdy = 0;
  endtask

  task automatic test_backpressure();
    drive_req(0, 40'h00_0000_0008, 3'd3, 64'h0, 0);
    tick(); scramble_req();
    l_ack = 1; tick(); l_ack = 0;
    drive_ret(4'h0, 64'h0123, 64'h4567, 2'b00);
    tick(); drop_ret();
    drive_req(1, 40'h00_0000_0100, 3'd0, 64'h77, 0);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({rsp_val, rsp_rdata, rsp_err, req_rdy} !== {1'b1, 64'h4567, 2'b00, 1'b0}) begin
        errors++;
        $display("FAIL bp_stable[%0d]: got val=%b data=%h rdy=%b, required 1 4567 0",
                 i, rsp_val, rsp_rdata, req_rdy);
      end
      tick();
    end
    rsp_rdy = 1; tick(); rsp_rdy = 0;
    checks++;
    if ({rsp_val, req_rdy, t_val} !== 3'b010) begin
      errors++;
      $display("FAIL bp_after_hs: got rsp_val=%b req_rdy=%b l15_val=%b, required 0 1 0",
               rsp_val, req_rdy, t_val);
    end
    tick(); scramble_req();
    checks++;
    if ({t_val, t_rqtype, t_nc, t_size, t_addr, t_data} !== model_req(1, 0, 3'd0, 40'h100, 64'h77)) begin
      errors++;
      $display("FAIL bp_next_req: got val=%b addr=%h, required 1 100", t_val, t_addr);
    end
    l_ack = 1; drive_ret(4'h4, 64'h0, 64'h0, 2'b00);
    tick(); l_ack = 0; drop_ret();
    checks++;
    if ({rsp_val, rsp_rdata} !== {1'b1, 64'h0}) begin
      errors++;
      $display("FAIL ack_with_ret: got val=%b data=%h, required 1 0", rsp_val, rsp_rdata);
    end
    rsp_rdy = 1; tick(); rsp_rdy = 0;
  endtask

  task automatic test_timeout();
    drive_req(0, 40'h00_0000_2000, 3'd3, 64'h0, 0);
    tick(); scramble_req();
    l_ack = 1; tick(); l_ack = 0;
    for (int k = 1; k <= 16; k++) begin
      checks++;
      if (rsp_timeout !== (k == 16)) begin
        errors++;
        $display("FAIL timeout_pulse[cycle %0d]: got %b required %b", k, rsp_timeout, (k == 16));
      end
      tick();
    end
    checks++;
    if ({rsp_val, rsp_rdata, rsp_err, rsp_timeout} !== {1'b1, 64'h0, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL timeout_rsp: got val=%b data=%h err=%h to=%b, required 1 0 3 0",
               rsp_val, rsp_rdata, rsp_err, rsp_timeout);
    end
    drive_ret(4'h0, 64'h9999, 64'h8888, 2'b00);
    #1;
    checks++;
    if (t_req_ack !== 1'b1) begin
      errors++;
      $display("FAIL late_ret_ack: got %b required 1", t_req_ack);
    end
    tick(); drop_ret();
    checks++;
    if ({rsp_val, rsp_rdata, rsp_err} !== {1'b1, 64'h0, 2'b11}) begin
      errors++;
      $display("FAIL late_ret_dropped: got val=%b data=%h err=%h, required 1 0 3", rsp_val, rsp_rdata, rsp_err);
    end
    rsp_rdy = 1; tick(); rsp_rdy = 0;
    checks++;
    if ({rsp_val, req_rdy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_idle: got rsp_val=%b req_rdy=%b, required 0 1", rsp_val, req_rdy);
    end
  endtask

  task automatic test_reset_mid();
    drive_req(1, 40'h00_0000_3000, 3'd1, 64'h1234, 1);
    tick(); scramble_req();
    l_ack = 1; tick(); l_ack = 0;
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    #1;
    checks++;
    if ({t_val, t_rqtype, t_nc, t_size, t_addr, t_data, rsp_val, rsp_rdata, rsp_err, rsp_timeout, t_req_ack} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got val=%b rq=%h addr=%h rsp_val=%b err=%h, required all 0",
               t_val, t_rqtype, t_addr, rsp_val, rsp_err);
    end
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_rdy: got %b required 1", req_rdy);
    end
  endtask

  task automatic test_random();
    logic        we, nc, same;
    logic [39:0] a;
    logic [2:0]  sz;
    logic [63:0] wd, d0, d1, tmp, exp_rd;
    logic [1:0]  e;
    logic [3:0]  junk;
    int          nj, ad, rd;
    for (int t = 0; t < 40; t++) begin
      we = $urandom_range(0, 1); nc = $urandom_range(0, 1);
      tmp = {$urandom, $urandom}; a = tmp[39:0];
      sz = 3'($urandom_range(0, 3));
      wd = {$urandom, $urandom}; d0 = {$urandom, $urandom}; d1 = {$urandom, $urandom};
      e = 2'($urandom_range(0, 3));
      ad = $urandom_range(0, 3); nj = $urandom_range(0, 2); rd = $urandom_range(0, 3);
      same = ($urandom_range(0, 3) == 0);
      exp_rd = model_rdata(we, a, d0, d1);
      drive_req(we, a, sz, wd, nc);
      #1;
      checks++;
      if (req_rdy !== 1'b1) begin
        errors++;
        $display("FAIL rnd_rdy[%0d]: got %b required 1", t, req_rdy);
      end
      tick(); scramble_req();
      for (int i = 0; i <= ad; i++) begin
        checks++;
        if ({t_val, t_rqtype, t_nc, t_size, t_addr, t_data} !== model_req(we, nc, sz, a, wd)) begin
          errors++;
          $display("FAIL rnd_req[%0d]: got val=%b rq=%h nc=%b sz=%h addr=%h data=%h, required we=%b nc=%b sz=%h addr=%h data=%h",
                   t, t_val, t_rqtype, t_nc, t_size, t_addr, t_data, we, nc, sz, a, wd);
        end
        if (i < ad) tick();
      end
      l_ack = 1;
      if (!same) begin
        tick(); l_ack = 0;
        for (int j = 0; j < nj; j++) begin
          case ($urandom_range(0, 2))
            0:       junk = 4'h3;
            1:       junk = 4'h7;
            default: junk = we ? 4'h0 : 4'h4;
          endcase
          drive_ret(junk, {$urandom, $urandom}, {$urandom, $urandom}, 2'b10);
          tick(); drop_ret();
          checks++;
          if ({rsp_val, t_val} !== 2'b00) begin
            errors++;
            $display("FAIL rnd_junk[%0d]: type %h got rsp_val=%b l15_val=%b, required 0 0",
                     t, junk, rsp_val, t_val);
          end
        end
      end
      drive_ret(we ? 4'h4 : 4'h0, d0, d1, e);
      #1;
      checks++;
      if (t_req_ack !== 1'b1) begin
        errors++;
        $display("FAIL rnd_req_ack[%0d]: got %b required 1", t, t_req_ack);
      end
      tick(); drop_ret(); l_ack = 0;
      for (int i = 0; i <= rd; i++) begin
        checks++;
        if ({rsp_val, rsp_rdata, rsp_err, req_rdy} !== {1'b1, exp_rd, e, 1'b0}) begin
          errors++;
          $display("FAIL rnd_rsp[%0d]: got val=%b data=%h err=%h rdy=%b, required 1 %h %h 0",
                   t, rsp_val, rsp_rdata, rsp_err, req_rdy, exp_rd, e);
        end
        if (i < rd) tick();
      end
      rsp_rdy = 1; tick(); rsp_rdy = 0;
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_hold();
    test_inv_drop();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
